// File: rtl/demux_deser4.sv
// demux_deser4: receive-side 4:1 time-slot deserializer.
// Collects four slot beats into one parallel word. Slot alignment comes from
// a sync marker on slot 0. A sync that arrives in the middle of a frame is
// counted as a framing error and restarts the frame at slot 0.
module demux_deser4 #(
   parameter int DATA_W = 1,
   parameter int ERR_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   din,
   input  logic                din_valid,
   input  logic                sync,
   output logic [4*DATA_W-1:0] o,
   output logic                o_valid,
   output logic [1:0]          slot,
   output logic                frame_err,
   output logic [ERR_W-1:0]    err_cnt
);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [1:0]          slot_reg, slot_next;
   logic [3*DATA_W-1:0] shadow_reg;
   logic [4*DATA_W-1:0] o_reg, o_next;
   logic                o_valid_reg, o_valid_next;
   logic                frame_err_reg, frame_err_next;
   logic [ERR_W-1:0]    err_cnt_reg, err_cnt_next;

   // Shadow write request: one enable plus the slot index it targets.
   logic                wr_en;
   logic [1:0]          wr_idx;
   logic [2:0]          shadow_we;

   logic                err_sat;
   assign err_sat = &err_cnt_reg;

   // Next-state and output decode; pulses default low so they last one cycle.
   always_comb begin
      state_next     = state_reg;
      slot_next      = slot_reg;
      o_next         = o_reg;
      o_valid_next   = 1'b0;
      frame_err_next = 1'b0;
      err_cnt_next   = err_cnt_reg;
      wr_en          = 1'b0;
      wr_idx         = 2'd0;
      if (din_valid) begin
         case (state_reg)
            HUNT: begin
               // Beats without sync are dropped silently while acquiring alignment.
               if (sync) begin
                  wr_en      = 1'b1;
                  wr_idx     = 2'd0;
                  slot_next  = 2'd1;
                  state_next = COLLECT;
               end
            end
            COLLECT: begin
               if (sync) begin
                  // Premature sync: abandon the partial frame and restart at slot 0.
                  frame_err_next = 1'b1;
                  if (!err_sat) begin
                     err_cnt_next = err_cnt_reg + 1'b1;
                  end
                  wr_en     = 1'b1;
                  wr_idx    = 2'd0;
                  slot_next = 2'd1;
               end else if (slot_reg == 2'd3) begin
                  // Last slot goes straight to the output word, never via the shadow.
                  o_next       = {din, shadow_reg};
                  o_valid_next = 1'b1;
                  slot_next    = 2'd0;
                  state_next   = HUNT;
               end else begin
                  wr_en     = 1'b1;
                  wr_idx    = slot_reg;
                  slot_next = slot_reg + 2'd1;
               end
            end
            default: begin
               state_next = HUNT;
               slot_next  = 2'd0;
            end
         endcase
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= HUNT;
         slot_reg      <= 2'd0;
         o_reg         <= '0;
         o_valid_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         slot_reg      <= slot_next;
         o_reg         <= o_next;
         o_valid_reg   <= o_valid_next;
         frame_err_reg <= frame_err_next;
         err_cnt_reg   <= err_cnt_next;
      end
   end

   // One shadow lane per held slot (slots 0..2).
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
         assign shadow_we[gi] = wr_en && (wr_idx == 2'(gi));

         // Capture the beat into this lane when it is the addressed slot.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_reg[gi*DATA_W +: DATA_W] <= '0;
            end else if (shadow_we[gi]) begin
               shadow_reg[gi*DATA_W +: DATA_W] <= din;
            end
         end
      end
   endgenerate

   assign o         = o_reg;
   assign o_valid   = o_valid_reg;
   assign slot      = slot_reg;
   assign frame_err = frame_err_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_demux_deser4.sv
// tb_demux_deser4: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based frame model.
module tb_demux_deser4;

   localparam int DW      = 4;
   localparam int EW      = 2;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DW-1:0]   din;
   logic            din_valid;
   logic            sync;
   logic [4*DW-1:0] o;
   logic            o_valid;
   logic [1:0]      slot;
   logic            frame_err;
   logic [EW-1:0]   err_cnt;

   int checks = 0;
   int errors = 0;

   demux_deser4 #(.DATA_W(DW), .ERR_W(EW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .sync      (sync),
      .o         (o),
      .o_valid   (o_valid),
      .slot      (slot),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: the partial frame is a queue of beats; an empty queue
   // means alignment has not been acquired.
   logic [DW-1:0]   part[$];
   logic [4*DW-1:0] m_o;
   bit              m_ov;
   bit              m_fe;
   int              m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      part.delete();
      m_o   = '0;
      m_ov  = 1'b0;
      m_fe  = 1'b0;
      m_err = 0;
   endfunction

   function automatic void model_step(input bit v, input bit s, input logic [DW-1:0] d);
      m_ov = 1'b0;
      m_fe = 1'b0;
      if (v) begin
         if (s) begin
            if (part.size() > 0) begin
               m_fe = 1'b1;
               if (m_err < ERR_MAX) m_err++;
            end
            part.delete();
            part.push_back(d);
         end else if (part.size() > 0) begin
            part.push_back(d);
            if (part.size() == 4) begin
               m_o  = {part[3], part[2], part[1], part[0]};
               m_ov = 1'b1;
               part.delete();
            end
         end
      end
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_o"},         32'(o),         32'(m_o));
      check({tag, "_o_valid"},   32'(o_valid),   32'(m_ov));
      check({tag, "_slot"},      32'(slot),      32'(part.size()));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(m_fe));
      check({tag, "_err_cnt"},   32'(err_cnt),   32'(m_err));
   endtask

   // One clock of stimulus; outputs are sampled 2 time units after the edge.
   task automatic step(input bit v, input bit s, input logic [DW-1:0] d, input string tag);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      model_step(v, s, d);
      #2;
      check_all(tag);
      if (m_ov) $display("%s: word o=%h", tag, o);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, tag);
   endtask

   // Reset asserted between edges: outputs must clear without waiting for clk.
   task automatic apply_reset(input string tag);
      din_valid = 1'b0;
      sync      = 1'b0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all({tag, "_async"});
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      check_all({tag, "_held"});
   endtask

   initial begin
      logic [3:0] basic_v[4];
      logic [3:0] hunt_v[4];
      logic [3:0] pre_v[4];
      int         sat_exp[5];
      bit         v;
      bit         s;

      basic_v = '{4'h0, 4'h1, 4'h0, 4'h1};
      hunt_v  = '{4'h1, 4'h1, 4'h0, 4'h0};
      pre_v   = '{4'h1, 4'h0, 4'h0, 4'h1};
      sat_exp = '{1, 2, 3, 3, 3};

      rst_n     = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;
      din       = '0;
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Basic frame
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, basic_v[i], "basic");
      check("basic_word", 32'(o), 32'h1010);
      check("basic_pulse", 32'(o_valid), 32'd1);
      idle(1, "basic_idle");
      check("basic_pulse_end", 32'(o_valid), 32'd0);

      // Gapped frame from a clean reset
      apply_reset("gap_rst");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0, basic_v[i], "gap");
         if (i < 3) begin
            idle(3, "gap_idle");
            check("gap_o_held", 32'(o), 32'h0);
         end
      end
      check("gap_word", 32'(o), 32'h1010);

      // Hunt discard
      step(1'b1, 1'b0, 4'h5, "hunt_drop");
      step(1'b1, 1'b0, 4'h7, "hunt_drop");
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, hunt_v[i], "hunt");
      check("hunt_word", 32'(o), 32'h0011);
      check("hunt_no_err", 32'(err_cnt), 32'd0);

      // Premature sync
      step(1'b1, 1'b1, 4'h9, "pre_part");
      step(1'b1, 1'b0, 4'h2, "pre_part");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i == 0, pre_v[i], "pre");
         if (i == 0) check("pre_err_pulse", 32'(frame_err), 32'd1);
         if (i < 3) check("pre_o_kept", 32'(o), 32'h0011);
      end
      check("pre_word", 32'(o), 32'h1001);
      check("pre_err_cnt", 32'(err_cnt), 32'd1);

      // Back-to-back frames
      for (int i = 0; i < 8; i++) step(1'b1, (i % 4) == 0, 4'(i + 3), "b2b");
      check("b2b_word", 32'(o), 32'hA987);

      // Counter saturation
      apply_reset("sat_rst");
      step(1'b1, 1'b1, 4'hC, "sat");
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 4'(i), "sat");
         check("sat_cnt", 32'(err_cnt), 32'(sat_exp[i]));
         check("sat_pulse", 32'(frame_err), 32'd1);
      end

      // Reset mid-frame
      apply_reset("mid_rst0");
      step(1'b1, 1'b1, 4'h6, "mid");
      step(1'b1, 1'b0, 4'h6, "mid");
      step(1'b1, 1'b0, 4'h6, "mid");
      apply_reset("mid_rst");
      check("mid_slot", 32'(slot), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, 4'h1, "mid_frame");
      check("mid_word", 32'(o), 32'h1111);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            apply_reset("rnd_rst");
         end else begin
            v = ($urandom_range(0, 9) < 7);
            s = (part.size() == 0) ? bit'($urandom_range(0, 1))
                                   : ($urandom_range(0, 15) == 0);
            step(v, s, 4'($urandom), "rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_deser4.md
# demux_deser4

Receive-side counterpart of the team's 4:1 time-slot multiplexer. The transmitter steps its select through slots 0..3 and drives one slot per beat. This block collects those beats back into a parallel 4-slot word and presents it with a one-cycle valid pulse. It sits at the far end of the serial link, directly after the line register, and recovers slot alignment from a frame-sync marker carried with slot 0.

## Interface
- DATA_W, default 1: width of one slot in bits. Slot k occupies o[k*DATA_W +: DATA_W].
- ERR_W, default 8: width of the saturating framing-error counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- din  in  DATA_W  slot data beat.
- din_valid  in  1  din carries a beat this cycle.
- sync  in  1  qualifies the current beat as slot 0; ignored when din_valid=0.
- o  out  4*DATA_W  last completed word; slot 0 in the LSBs.
- o_valid  out  1  one-cycle pulse; o was updated this cycle.
- slot  out  2  index the next accepted beat will be written to.
- frame_err  out  1  one-cycle pulse on a framing error.
- err_cnt  out  ERR_W  count of framing errors, saturating at all-ones.

## Operation
- Internal state: FSM {HUNT, COLLECT}, 2-bit slot counter, 3*DATA_W shadow for slots 0..2.
- Reset values (asynchronous): state=HUNT, slot=0, shadow=0, o=0, o_valid=0, frame_err=0, err_cnt=0.
- A beat is din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulse outputs.
- HUNT:
  - Beat with sync=1: write din to shadow slot 0, slot<=1, go to COLLECT.
  - Beat with sync=0: discard it. No error is flagged; the block is still acquiring alignment.
- COLLECT, beat with sync=0:
  - When slot is 1 or 2: write din to shadow[slot], slot<=slot+1.
  - When slot=3: o<={din, shadow[2], shadow[1], shadow[0]}, o_valid<=1, slot<=0 (wrap), go to HUNT.
- COLLECT, beat with sync=1 (premature sync):
  - frame_err<=1 and err_cnt<=err_cnt+1 unless err_cnt is saturated.
  - Discard the partial frame. Treat the beat as a new slot 0: write shadow slot 0, slot<=1, stay in COLLECT.
- o holds its value between completions. A partial or aborted frame never alters o.
- o_valid and frame_err are registered pulses. Each is high for exactly one cycle per event and is never high in the same cycle as the other.
- Every frame requires a fresh sync. Back-to-back frames need sync=1 on the beat immediately after slot 3.

## Timing
- Latency: the slot-3 beat is sampled at edge N. o and o_valid are visible after edge N, so o_valid is high in the cycle after the beat was presented.
- Minimum frame: 4 consecutive valid cycles. Maximum throughput: one word per 4 cycles, so o_valid may pulse every 4th cycle.
- Gaps (din_valid=0) inside a frame are allowed and unlimited in length. There is no timeout.
- frame_err asserts in the cycle after the offending sync beat. err_cnt updates in the same cycle.
- Asserting rst_n=0 mid-frame immediately clears all outputs and state, and discards the partial frame. The first frame after reset requires sync.

## Test plan
- Basic frame, DATA_W=1: beats din=0,1,0,1 with sync=1 on the first beat only -> o=4'b1010, o_valid high for 1 cycle, slot reads 1,2,3,0 after each beat.
- Gapped frame: same beats with 3 idle cycles between each -> identical o=4'b1010; o_valid only after the 4th beat; o unchanged (0) before that.
- Hunt discard: 2 beats with sync=0, then a frame 1,1,0,0 with sync on the first -> o=4'b0011, frame_err never asserted, err_cnt=0.
- Premature sync: sync beat plus 1 beat, then a new sync frame 1,0,0,1 -> frame_err pulses once, err_cnt=1, o=4'b1001, previous o retained until then.
- Saturation, ERR_W=2: 5 premature syncs -> err_cnt reads 1,2,3,3,3 and frame_err pulses 5 times.
- Reset mid-frame: after 3 beats assert rst_n=0 for 1 cycle -> o=0, slot=0, o_valid=0; a subsequent full frame 1,1,1,1 -> o=4'b1111.
